// File: rtl/lsu_exc_ctl_pkg.sv
// Shared LSU types for the exception pipeline: dc1 packet, stage entry and dc3 error report.
package lsu_exc_ctl_pkg;

    localparam int unsigned LSU_ADDR_W = 32;

    localparam logic [1:0] LSU_EXC_ACCESS   = 2'd0;
    localparam logic [1:0] LSU_EXC_MISALIGN = 2'd1;

    typedef struct packed {
        logic valid;
        logic load;
        logic store;
        logic dma;
    } lsu_pkt_t;

    typedef struct packed {
        logic                  exc_valid;
        logic                  inst_type;
        logic [1:0]            exc_type;
        logic                  ecc_error;
        logic [LSU_ADDR_W-1:0] addr;
    } lsu_error_pkt_t;

    // valid must stay the most significant field: the stage register splits it off by position
    typedef struct packed {
        logic                  valid;
        logic                  store;
        logic                  dma;
        logic                  in_dccm;
        logic                  mis;
        logic                  acc;
        logic [LSU_ADDR_W-1:0] addr;
    } exc_stage_t;

    localparam int unsigned EXC_STAGE_W = $bits(exc_stage_t);

    function automatic lsu_error_pkt_t exc_pkt(input exc_stage_t s, input logic dbl_ecc);
        lsu_error_pkt_t p;
        logic           ev;
        p  = '0;
        ev = s.valid & ~s.dma & (s.mis | s.acc | (s.in_dccm & dbl_ecc));
        if (ev) begin
            p.exc_valid = 1'b1;
            p.inst_type = s.store;
            p.addr      = s.addr;
            p.exc_type  = s.mis ? LSU_EXC_MISALIGN : LSU_EXC_ACCESS;
            p.ecc_error = ~s.mis & ~s.acc;
        end
        return p;
    endfunction

endpackage

// File: rtl/lsu_exc_stage.sv
// One exception pipeline stage: holds on i_hold, drops valid on i_kill (kill beats hold).
module lsu_exc_stage
    import lsu_exc_ctl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_l,
    input  logic       i_hold,
    input  logic       i_kill,
    input  exc_stage_t i_d,
    output exc_stage_t o_q
);

    logic                   w_valid_en;
    logic                   w_valid_d;
    logic                   w_valid_q;
    logic [EXC_STAGE_W-2:0] w_data_d;
    logic [EXC_STAGE_W-2:0] w_data_q;

    assign w_valid_en = i_kill | ~i_hold;
    assign w_valid_d  = i_d.valid & ~i_kill;
    assign w_data_d   = i_d[EXC_STAGE_W-2:0];

    rvdffs #(.WIDTH(1)) u_valid_ff (
        .i_clk   (i_clk),
        .i_rst_l (i_rst_l),
        .i_en    (w_valid_en),
        .i_din   (w_valid_d),
        .o_dout  (w_valid_q)
    );

    // Payload is don't-care once killed, so it only needs the hold enable.
    rvdffs #(.WIDTH(EXC_STAGE_W-1)) u_data_ff (
        .i_clk   (i_clk),
        .i_rst_l (i_rst_l),
        .i_en    (~i_hold),
        .i_din   (w_data_d),
        .o_dout  (w_data_q)
    );

    assign o_q = {w_valid_q, w_data_q};

endmodule

// File: rtl/rvdffs.sv
// Enabled flop bank with synchronous active-low reset.
module rvdffs #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_l,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_l) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_din;
        end
    end

    assign o_dout = r_q;

endmodule

// File: rtl/lsu_exc_ctl.sv
// LSU exception pipeline: stages dc1 faults to dc3, merges DCCM ECC, and keeps a sticky
// first-exception record acknowledged by the trap logic.
module lsu_exc_ctl
    import lsu_exc_ctl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  lsu_pkt_t             lsu_pkt_dc1,
    input  logic [ADDR_W-1:0]    start_addr_dc1,
    input  logic                 access_fault_dc1,
    input  logic                 misaligned_fault_dc1,
    input  logic                 addr_in_dccm_dc1,
    input  logic                 lsu_freeze_dc3,
    input  logic                 lsu_flush_dc2_up,
    input  logic                 lsu_double_ecc_error_dc3,
    input  logic                 dec_tlu_exc_ack,
    output lsu_error_pkt_t       lsu_error_pkt_dc3,
    output logic                 lsu_exc_pending,
    output logic [1:0]           lsu_exc_type_sticky,
    output logic [ADDR_W-1:0]    lsu_exc_addr_sticky
);

    typedef enum logic {
        StIdle,
        StPend
    } sticky_state_e;

    exc_stage_t     w_dc1;
    exc_stage_t     w_dc2;
    exc_stage_t     w_dc3;
    lsu_error_pkt_t w_pkt_dc3;
    logic           w_qual;
    logic           w_capture;

    sticky_state_e     r_state;
    sticky_state_e     w_state_d;
    logic [1:0]        r_exc_type;
    logic [1:0]        w_exc_type_d;
    logic [ADDR_W-1:0] r_exc_addr;
    logic [ADDR_W-1:0] w_exc_addr_d;

    // DMA and invalid slots never carry architectural faults.
    assign w_qual = lsu_pkt_dc1.valid & ~lsu_pkt_dc1.dma;

    always_comb begin
        w_dc1         = '0;
        w_dc1.valid   = lsu_pkt_dc1.valid;
        w_dc1.store   = lsu_pkt_dc1.store;
        w_dc1.dma     = lsu_pkt_dc1.dma;
        w_dc1.in_dccm = addr_in_dccm_dc1;
        w_dc1.mis     = misaligned_fault_dc1 & w_qual;
        w_dc1.acc     = access_fault_dc1 & w_qual;
        w_dc1.addr    = LSU_ADDR_W'(start_addr_dc1);
    end

    lsu_exc_stage u_dc2 (
        .i_clk   (clk),
        .i_rst_l (rst_l),
        .i_hold  (lsu_freeze_dc3),
        .i_kill  (lsu_flush_dc2_up),
        .i_d     (w_dc1),
        .o_q     (w_dc2)
    );

    lsu_exc_stage u_dc3 (
        .i_clk   (clk),
        .i_rst_l (rst_l),
        .i_hold  (lsu_freeze_dc3),
        .i_kill  (lsu_flush_dc2_up),
        .i_d     (w_dc2),
        .o_q     (w_dc3)
    );

    assign w_pkt_dc3         = exc_pkt(w_dc3, lsu_double_ecc_error_dc3);
    assign lsu_error_pkt_dc3 = w_pkt_dc3;
    assign w_capture         = w_pkt_dc3.exc_valid & ~lsu_freeze_dc3;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state    <= StIdle;
            r_exc_type <= '0;
            r_exc_addr <= '0;
        end else begin
            r_state    <= w_state_d;
            r_exc_type <= w_exc_type_d;
            r_exc_addr <= w_exc_addr_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_exc_type_d = r_exc_type;
        w_exc_addr_d = r_exc_addr;
        unique case (r_state)
            StIdle: begin
                if (w_capture) begin
                    w_state_d    = StPend;
                    w_exc_type_d = w_pkt_dc3.exc_type;
                    w_exc_addr_d = ADDR_W'(w_pkt_dc3.addr);
                end
            end
            StPend: begin
                // An ack frees the record, so a same-cycle new error takes its place.
                if (dec_tlu_exc_ack) begin
                    if (w_capture) begin
                        w_exc_type_d = w_pkt_dc3.exc_type;
                        w_exc_addr_d = ADDR_W'(w_pkt_dc3.addr);
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign lsu_exc_pending     = (r_state == StPend);
    assign lsu_exc_type_sticky = r_exc_type;
    assign lsu_exc_addr_sticky = r_exc_addr;

endmodule

// File: tb/tb_lsu_exc_ctl.sv
// Self-checking bench for lsu_exc_ctl: transaction-queue model plus directed literal checks.
module tb_lsu_exc_ctl;
    import lsu_exc_ctl_pkg::*;

    logic           clk;
    logic           rst_l;
    lsu_pkt_t       pkt;
    logic [31:0]    addr;
    logic           acc;
    logic           mis;
    logic           dccm;
    logic           freeze;
    logic           flush;
    logic           ecc;
    logic           ack;
    lsu_error_pkt_t err_pkt;
    logic           pending;
    logic [1:0]     st_type;
    logic [31:0]    st_addr;

    int total = 0;
    int bad   = 0;

    lsu_exc_ctl #(.ADDR_W(32)) dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .lsu_pkt_dc1              (pkt),
        .start_addr_dc1           (addr),
        .access_fault_dc1         (acc),
        .misaligned_fault_dc1     (mis),
        .addr_in_dccm_dc1         (dccm),
        .lsu_freeze_dc3           (freeze),
        .lsu_flush_dc2_up         (flush),
        .lsu_double_ecc_error_dc3 (ecc),
        .dec_tlu_exc_ack          (ack),
        .lsu_error_pkt_dc3        (err_pkt),
        .lsu_exc_pending          (pending),
        .lsu_exc_type_sticky      (st_type),
        .lsu_exc_addr_sticky      (st_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted access is a transaction tagged with the pipeline stage it occupies.
    typedef struct {
        int          stage;
        logic        store;
        logic        dma;
        logic        dccm;
        logic        mis;
        logic        acc;
        logic [31:0] addr;
    } tx_t;

    tx_t         q[$];
    logic        m_started = 1'b0;
    logic        m_pend    = 1'b0;
    logic [1:0]  m_type    = 2'd0;
    logic [31:0] m_addr    = 32'd0;

    function automatic logic [36:0] lit(input logic ev, input logic it, input logic [1:0] ty,
                                        input logic ec, input logic [31:0] a);
        return {ev, it, ty, ec, a};
    endfunction

    function automatic logic [36:0] model_pkt();
        logic [36:0] r;
        r = '0;
        foreach (q[i]) begin
            if (q[i].stage == 3 && !q[i].dma) begin
                if (q[i].mis)
                    r = lit(1'b1, q[i].store, 2'd1, 1'b0, q[i].addr);
                else if (q[i].acc)
                    r = lit(1'b1, q[i].store, 2'd0, 1'b0, q[i].addr);
                else if (q[i].dccm && ecc)
                    r = lit(1'b1, q[i].store, 2'd0, 1'b1, q[i].addr);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [36:0] e;
        logic        cap;
        tx_t         nq[$];
        tx_t         t;
        m_started = 1'b1;
        if (!rst_l) begin
            q.delete();
            m_pend = 1'b0;
            m_type = 2'd0;
            m_addr = 32'd0;
        end else begin
            e   = model_pkt();
            cap = e[36] && !freeze;
            if (cap && (!m_pend || ack)) begin
                m_pend = 1'b1;
                m_type = e[34:33];
                m_addr = e[31:0];
            end else if (!cap && ack) begin
                m_pend = 1'b0;
            end
            if (flush) begin
                q.delete();
            end else if (!freeze) begin
                nq.delete();
                foreach (q[i]) begin
                    if (q[i].stage == 2) begin
                        t       = q[i];
                        t.stage = 3;
                        nq.push_back(t);
                    end
                end
                if (pkt.valid) begin
                    t.stage = 2; t.store = pkt.store; t.dma = pkt.dma; t.dccm = dccm;
                    t.mis = mis; t.acc = acc; t.addr = addr;
                    nq.push_back(t);
                end
                q = nq;
            end
        end
    end

    // Compare process: every cycle once the model has seen its first edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("model_pkt", 64'(err_pkt), 64'(model_pkt()));
            chk("model_pending", 64'(pending), 64'(m_pend));
            if (m_pend) begin
                chk("model_sticky_type", 64'(st_type), 64'(m_type));
                chk("model_sticky_addr", 64'(st_addr), 64'(m_addr));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        pkt = '0; addr = '0; acc = 1'b0; mis = 1'b0; dccm = 1'b0;
        freeze = 1'b0; flush = 1'b0; ecc = 1'b0; ack = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic dm, input logic ac,
                         input logic ms, input logic dc, input logic [31:0] a);
        pkt.valid = 1'b1; pkt.load = ld; pkt.store = st; pkt.dma = dm;
        acc = ac; mis = ms; dccm = dc; addr = a;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        rst_l = 1'b0;
        tick();
        tick();
        #1;
        chk("reset_pkt", 64'(err_pkt), 64'd0);
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_type", 64'(st_type), 64'd0);
        chk("reset_addr", 64'(st_addr), 64'd0);
        rst_l = 1'b1;
        tick();

        // Misaligned load, two cycles to dc3, sticky one cycle after.
        issue(1, 0, 0, 0, 1, 0, 32'h8000_0003); tick();
        idle(); tick();
        #1 chk("mis_load_pkt", 64'(err_pkt), 64'(lit(1, 0, 2'd1, 0, 32'h8000_0003)));
        tick();
        #1 chk("mis_load_pend", 64'(pending), 64'd1);
        chk("mis_load_st_type", 64'(st_type), 64'd1);
        chk("mis_load_st_addr", 64'(st_addr), 64'h8000_0003);
        ack_pulse();
        chk("ack_clears", 64'(pending), 64'd0);

        // Store with both faults: misaligned wins.
        issue(0, 1, 0, 1, 1, 0, 32'hF004_0001); tick();
        idle(); tick();
        #1 chk("both_store_pkt", 64'(err_pkt), 64'(lit(1, 1, 2'd1, 0, 32'hF004_0001)));
        tick();
        ack_pulse();

        // Same with DMA: never reported.
        issue(0, 1, 1, 1, 1, 0, 32'hF004_0001); tick();
        idle(); tick();
        #1 chk("dma_pkt", 64'(err_pkt), 64'd0);
        tick();
        #1 chk("dma_pend", 64'(pending), 64'd0);

        // DCCM double ECC at dc3.
        issue(1, 0, 0, 0, 0, 1, 32'h0000_1000); tick();
        idle(); tick();
        ecc = 1'b1;
        #1 chk("ecc_pkt", 64'(err_pkt), 64'(lit(1, 0, 2'd0, 1, 32'h0000_1000)));
        tick();
        ecc = 1'b0;
        #1 chk("ecc_pend", 64'(pending), 64'd1);
        ack_pulse();
        issue(1, 0, 0, 0, 0, 0, 32'h0000_1000); tick();
        idle(); tick();
        ecc = 1'b1;
        #1 chk("ecc_not_dccm", 64'(err_pkt), 64'd0);
        tick();
        idle();

        // Flush: dc3 fault reports, dc2 and dc1 faults die.
        issue(1, 0, 0, 1, 0, 0, 32'h0000_0200); tick();
        issue(1, 0, 0, 1, 0, 0, 32'h0000_0100); tick();
        issue(1, 0, 0, 0, 1, 0, 32'h0000_0300); flush = 1'b1;
        #1 chk("flush_dc3_pkt", 64'(err_pkt), 64'(lit(1, 0, 2'd0, 0, 32'h0000_0200)));
        tick();
        idle();
        #1 chk("flush_dc2_killed", 64'(err_pkt), 64'd0);
        chk("flush_st_addr", 64'(st_addr), 64'h0000_0200);
        tick();
        #1 chk("flush_dc1_killed", 64'(err_pkt), 64'd0);
        ack_pulse();

        // Freeze three cycles with a fault in dc3.
        issue(0, 1, 0, 0, 1, 0, 32'h0000_0400); tick();
        idle(); tick();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("freeze_pkt", 64'(err_pkt), 64'(lit(1, 1, 2'd1, 0, 32'h0000_0400)));
            chk("freeze_no_capture", 64'(pending), 64'd0);
            tick();
        end
        freeze = 1'b0;
        #1 chk("freeze_pkt_last", 64'(err_pkt), 64'(lit(1, 1, 2'd1, 0, 32'h0000_0400)));
        chk("freeze_still_idle", 64'(pending), 64'd0);
        tick();
        #1 chk("freeze_captured", 64'(st_addr), 64'h0000_0400);
        chk("freeze_pkt_gone", 64'(err_pkt), 64'd0);

        // First error wins while pending.
        issue(1, 0, 0, 1, 0, 0, 32'h0000_0500); tick();
        idle(); tick();
        #1 chk("second_pkt", 64'(err_pkt), 64'(lit(1, 0, 2'd0, 0, 32'h0000_0500)));
        tick();
        #1 chk("first_wins_addr", 64'(st_addr), 64'h0000_0400);
        chk("first_wins_type", 64'(st_type), 64'd1);

        // Ack in the same cycle as a new fault: record replaced, stays pending.
        issue(0, 1, 0, 1, 0, 0, 32'h0000_0600); tick();
        idle(); tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1 chk("ack_fault_pend", 64'(pending), 64'd1);
        chk("ack_fault_addr", 64'(st_addr), 64'h0000_0600);
        chk("ack_fault_type", 64'(st_type), 64'd0);
        ack_pulse();
        chk("ack_alone", 64'(pending), 64'd0);
        ack_pulse();
        chk("ack_in_idle", 64'(pending), 64'd0);

        // Reset mid-pipeline discards the in-flight fault.
        issue(1, 0, 0, 0, 1, 0, 32'h0000_0700); tick();
        idle(); rst_l = 1'b0; tick();
        rst_l = 1'b1;
        #1 chk("midreset_pkt", 64'(err_pkt), 64'd0);
        tick();
        #1 chk("midreset_pkt2", 64'(err_pkt), 64'd0);
        chk("midreset_pend", 64'(pending), 64'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
